// File: rtl/hpdl_pkg.sv
// hpdl_pkg: shared character codes and refresh sequencer states for the HPDL-1414 driver.
package hpdl_pkg;
    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_CARET = 8'h5F;
    localparam logic [7:0] CHR_BKSP  = 8'h08;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_QMARK = 8'h3F;
    typedef enum logic [1:0] {SETUP, STROBE, HOLD} seq_state_t;
endpackage

// File: rtl/hpdl_refresh_seq.sv
// hpdl_refresh_seq: per-digit setup/strobe/hold timing, digit walk, frame pulse and caret blink phase.
module hpdl_refresh_seq
    import hpdl_pkg::*;
#(
    parameter int N_CHIPS      = 4,
    parameter int CARET_EN     = 1,
    parameter int BLINK_FRAMES = 64,
    parameter int SETUP_CYC    = 4,
    parameter int WR_CYC       = 8,
    parameter int HOLD_CYC     = 2,
    localparam int DEPTH       = 4 * N_CHIPS,
    localparam int CW          = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [CW-1:0]      cursor,
    input  logic               line_full,
    input  logic [6:0]         chr,
    output logic [CW-1:0]      digit,
    output logic [6:0]         hpdl_data,
    output logic [1:0]         hpdl_addr,
    output logic [N_CHIPS-1:0] hpdl_wr_n,
    output logic               frame_done
);
    seq_state_t state, state_n;
    logic [15:0] cnt, fcnt;
    logic [CW-1:0] d, nxt, d_n;
    logic last, wrap, frame_end, ph_n, phase;

    always_comb begin
        last = cnt == (state == SETUP ? 16'(SETUP_CYC - 1) : state == STROBE ? 16'(WR_CYC - 1) : 16'(HOLD_CYC - 1));
        state_n = !last ? state : state == SETUP ? STROBE : state == STROBE ? HOLD : SETUP;
        wrap = last && state == HOLD;
        frame_end = wrap && d == CW'(DEPTH - 1);
        nxt = frame_end ? '0 : d + CW'(1);
        d_n = wrap ? nxt : d;
        // the first digit of a new frame must already see the toggled phase
        ph_n = frame_end && fcnt == 16'(BLINK_FRAMES - 1) ? !phase : phase;
        hpdl_wr_n = '1;
        for (int i = 0; i < N_CHIPS; i++)
            if (state == STROBE && (d >> 2) == CW'(i)) hpdl_wr_n[i] = 1'b0;
    end

    assign digit = nxt;

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state      <= SETUP;
            cnt        <= '0;
            d          <= '0;
            hpdl_addr  <= '0;
            hpdl_data  <= CHR_SPACE[6:0];
            frame_done <= 1'b0;
            fcnt       <= '0;
            phase      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= last ? '0 : cnt + 16'd1;
            d          <= d_n;
            hpdl_addr  <= 2'd3 - d_n[1:0];
            frame_done <= frame_end;
            if (wrap)
                hpdl_data <= CARET_EN != 0 && nxt == cursor && !line_full && ph_n ? CHR_CARET[6:0] : chr;
            if (frame_end) begin
                fcnt  <= fcnt == 16'(BLINK_FRAMES - 1) ? '0 : fcnt + 16'd1;
                phase <= ph_n;
            end
        end
endmodule

// File: rtl/hpdl_display_ctrl.sv
// hpdl_display_ctrl: byte-stream text buffer with cursor, scroll/wrap and clear,
// driving N_CHIPS HPDL-1414 displays through the refresh sequencer.
module hpdl_display_ctrl
    import hpdl_pkg::*;
#(
    parameter int N_CHIPS      = 4,
    parameter int SCROLL_MODE  = 1,
    parameter int FOLD_CASE    = 1,
    parameter int CARET_EN     = 1,
    parameter int BLINK_FRAMES = 64,
    parameter int SETUP_CYC    = 4,
    parameter int WR_CYC       = 8,
    parameter int HOLD_CYC     = 2,
    localparam int DEPTH       = 4 * N_CHIPS,
    localparam int CW          = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic [6:0]         hpdl_data,
    output logic [1:0]         hpdl_addr,
    output logic [N_CHIPS-1:0] hpdl_wr_n,
    output logic [CW-1:0]      cursor,
    output logic               frame_done
);
    logic [7:0] text [DEPTH];
    logic [CW-1:0] clr_idx, rd_idx;
    logic [7:0] chr;
    logic line_full, clr, xfer, printable;

    always_comb begin
        xfer = in_valid && in_ready;
        printable = !in_data[7] && in_data[6:5] != 2'b00;
        chr = !(in_data[6] && in_data[5]) ? in_data : FOLD_CASE != 0 ? in_data - 8'h20 : CHR_QMARK;
    end

    assign in_ready = !clr;

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) text[i] <= CHR_SPACE;
            cursor    <= '0;
            line_full <= 1'b0;
            clr       <= 1'b0;
            clr_idx   <= '0;
        end else if (clr) begin
            text[clr_idx] <= CHR_SPACE;
            clr_idx       <= clr_idx + CW'(1);
            if (clr_idx == CW'(DEPTH - 1)) begin
                clr       <= 1'b0;
                cursor    <= '0;
                line_full <= 1'b0;
            end
        end else if (xfer) begin
            if (printable) begin
                if (!line_full) begin
                    text[cursor] <= chr;
                    if (cursor == CW'(DEPTH - 1)) line_full <= 1'b1;
                    else cursor <= cursor + CW'(1);
                end else if (SCROLL_MODE != 0) begin
                    for (int i = 0; i < DEPTH - 1; i++) text[i] <= text[i+1];
                    text[DEPTH-1] <= chr;
                end else begin
                    text[0]   <= chr;
                    cursor    <= CW'(1);
                    line_full <= 1'b0;
                end
            end else if (in_data == CHR_BKSP) begin
                // a full line keeps its cursor on the last digit, so only the flag unwinds
                if (line_full) begin
                    text[DEPTH-1] <= CHR_SPACE;
                    line_full     <= 1'b0;
                end else if (cursor != '0) begin
                    cursor                  <= cursor - CW'(1);
                    text[cursor - CW'(1)]   <= CHR_SPACE;
                end
            end else if (in_data == CHR_CR) begin
                cursor    <= '0;
                line_full <= 1'b0;
            end else if (in_data == CHR_FF) begin
                clr     <= 1'b1;
                clr_idx <= '0;
            end
        end

    hpdl_refresh_seq #(
        .N_CHIPS(N_CHIPS), .CARET_EN(CARET_EN), .BLINK_FRAMES(BLINK_FRAMES),
        .SETUP_CYC(SETUP_CYC), .WR_CYC(WR_CYC), .HOLD_CYC(HOLD_CYC)
    ) u_seq (
        .CLK(CLK),
        .RST(RST),
        .cursor(cursor),
        .line_full(line_full),
        .chr(text[rd_idx][6:0]),
        .digit(rd_idx),
        .hpdl_data(hpdl_data),
        .hpdl_addr(hpdl_addr),
        .hpdl_wr_n(hpdl_wr_n),
        .frame_done(frame_done)
    );
endmodule

// File: tb/tb_hpdl_display_ctrl.sv
// tb_hpdl_display_ctrl: directed checks of three configurations (scroll/fold/caret, wrap/no-fold, 4 chips).
module tb_hpdl_display_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic ra, rb, rc, fa, fb, fc;
    logic [6:0] da, db, dc;
    logic [1:0] aa, ab, ac, ca, cb;
    logic wa, wb;
    logic [3:0] wc, cc;
    int checks = 0, failures = 0, nfd = 0;

    always #5 clk = ~clk;

    hpdl_display_ctrl #(.N_CHIPS(1), .SCROLL_MODE(1), .FOLD_CASE(1), .CARET_EN(1), .BLINK_FRAMES(1)) u_a (
        .CLK(clk), .RST(rst), .in_valid(va), .in_data(in_data), .in_ready(ra), .hpdl_data(da),
        .hpdl_addr(aa), .hpdl_wr_n(wa), .cursor(ca), .frame_done(fa));
    hpdl_display_ctrl #(.N_CHIPS(1), .SCROLL_MODE(0), .FOLD_CASE(0), .CARET_EN(0), .BLINK_FRAMES(1)) u_b (
        .CLK(clk), .RST(rst), .in_valid(vb), .in_data(in_data), .in_ready(rb), .hpdl_data(db),
        .hpdl_addr(ab), .hpdl_wr_n(wb), .cursor(cb), .frame_done(fb));
    hpdl_display_ctrl #(.N_CHIPS(4), .CARET_EN(0)) u_c (
        .CLK(clk), .RST(rst), .in_valid(vc), .in_data(in_data), .in_ready(rc), .hpdl_data(dc),
        .hpdl_addr(ac), .hpdl_wr_n(wc), .cursor(cc), .frame_done(fc));

    always @(negedge clk or posedge rst)
        if (rst) nfd <= 0;
        else if (fa) nfd <= nfd + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] m, input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while ((m & {rc, rb, ra}) != m && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("send_ready_timeout", t, 0);
        in_data = b;
        {vc, vb, va} = m;
        @(negedge clk);
        {vc, vb, va} = 3'b000;
    endtask

    task automatic sends(input logic [2:0] m, input string s);
        for (int i = 0; i < s.len(); i++) send(m, s[i]);
    endtask

    task automatic wait_fd(input bit use_c, input string tag);
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while ((use_c ? fc : fa) !== 1'b1 && t < 400);
        chk(tag, t < 400, 1);
    endtask

    // one frame of u_a and u_b (they run in lockstep); caret expected on odd frames
    task automatic cap(input string tag, input logic [31:0] ea, input logic [31:0] eb, input int cur, input bit lf);
        int t, len;
        logic [7:0] e, f;
        bit ph;
        wait_fd(0, {tag, "_fd"});
        chk({tag, "_fd_b"}, fb, 1);
        #1 ph = nfd[0];
        for (int j = 0; j < 4; j++) begin
            t = 0;
            while (wa !== 1'b0 && t < 40) begin @(negedge clk); t++; end
            e = ea[31-8*j -: 8];
            f = eb[31-8*j -: 8];
            if (!lf && j == cur && ph) e = 8'h5F;
            chk($sformatf("%s_a_data%0d", tag, j), da, e[6:0]);
            chk($sformatf("%s_b_data%0d", tag, j), db, f[6:0]);
            chk($sformatf("%s_a_addr%0d", tag, j), aa, 3 - j);
            chk($sformatf("%s_b_addr%0d", tag, j), ab, 3 - j);
            chk($sformatf("%s_b_wr%0d", tag, j), wb, 0);
            len = 0;
            while (wa === 1'b0 && len < 40) begin @(negedge clk); len++; end
            chk($sformatf("%s_a_strobe%0d", tag, j), len, 8);
        end
    endtask

    initial begin
        int t, n;
        logic [3:0] m4;
        repeat (2) @(negedge clk);
        chk("rst_wr_a", wa, 1);
        chk("rst_wr_c", wc, 4'hF);
        chk("rst_data", da, 7'h20);
        chk("rst_data_c", dc, 7'h20);
        chk("rst_addr", aa, 0);
        chk("rst_ready", ra, 1);
        chk("rst_fd", fa, 0);
        chk("rst_cursor_a", ca, 0);
        chk("rst_cursor_c", cc, 0);
        rst = 1'b0;

        cap("blank", 32'h20202020, 32'h20202020, 0, 0);
        wait_fd(0, "period_fd");
        n = 0;
        do begin @(negedge clk); n++; end while (fa !== 1'b1 && n < 200);
        chk("frame_period", n, 56);

        sends(3'b011, "ABCD");
        chk("abcd_cursor_a", ca, 3);
        chk("abcd_cursor_b", cb, 3);
        cap("abcd", 32'h41424344, 32'h41424344, 3, 1);

        send(3'b011, "E");
        chk("e_cursor_a", ca, 3);
        chk("e_cursor_b", cb, 1);
        cap("scroll_wrap", 32'h42434445, 32'h45424344, 3, 1);

        send(3'b011, 8'h0D);
        chk("cr_cursor_a", ca, 0);
        send(3'b011, "a");
        chk("fold_cursor_a", ca, 1);
        chk("fold_cursor_b", cb, 1);
        cap("fold1", 32'h41434445, 32'h3F424344, 1, 0);
        cap("fold2", 32'h41434445, 32'h3F424344, 1, 0);

        send(3'b011, 8'h0C);
        sends(3'b011, "AB");
        send(3'b011, 8'h08);
        chk("bksp_cursor_a", ca, 1);
        chk("bksp_cursor_b", cb, 1);
        cap("bksp", 32'h41202020, 32'h41202020, 1, 0);
        send(3'b011, 8'h08);
        send(3'b011, 8'h08);
        chk("bksp0_cursor_a", ca, 0);
        sends(3'b011, "WXYZ");
        send(3'b011, 8'h08);
        chk("bksp_full_cursor", ca, 3);
        cap("bksp_full", 32'h57585920, 32'h57585920, 3, 0);

        send(3'b011, 8'h80);
        send(3'b011, 8'h07);
        chk("ignore_cursor_a", ca, 3);
        chk("ignore_cursor_b", cb, 3);
        cap("ignore", 32'h57585920, 32'h57585920, 3, 0);

        sends(3'b100, "HI");
        chk("c_cursor_hi", cc, 2);
        @(negedge clk);
        in_data = 8'h0C;
        vc = 1'b1;
        @(negedge clk);
        in_data = 8'h01;
        n = 0;
        while (rc === 1'b0 && n < 100) begin @(negedge clk); n++; end
        vc = 1'b0;
        chk("c_ready_low", n, 16);
        chk("c_cursor_ff", cc, 0);
        wait_fd(1, "c_fd");
        for (int j = 0; j < 16; j++) begin
            t = 0;
            while (wc === 4'hF && t < 40) begin @(negedge clk); t++; end
            m4 = ~(4'b0001 << (j / 4));
            chk($sformatf("c_wr%0d", j), wc, m4);
            chk($sformatf("c_addr%0d", j), ac, 3 - j % 4);
            chk($sformatf("c_data%0d", j), dc, 7'h20);
            t = 0;
            while (wc !== 4'hF && t < 40) begin @(negedge clk); t++; end
        end

        t = 0;
        while (wa !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_a", wa, 1);
        chk("arst_data", da, 7'h20);
        chk("arst_addr", aa, 0);
        chk("arst_cursor", ca, 0);
        chk("arst_ready", ra, 1);
        @(negedge clk);
        rst = 1'b0;
        cap("post_rst", 32'h20202020, 32'h20202020, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
